// File: rtl/scan_shifter.sv
// Multi-lane parallel-load / serial-shift scan register for the self-test path.
// Loads a WIDTH-bit word, shifts it out MSB-first per lane, capturing or rotating.

module scan_lane #(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           shift,
  input  logic           rot,
  input  logic [SEG-1:0] din,
  input  logic           sin,
  output logic [SEG-1:0] seg,
  output logic           sout
);
  logic           in_bit;
  logic [SEG-1:0] nxt;

  // Rotate feeds the outgoing MSB straight back into the LSB.
  assign in_bit = rot ? seg[SEG-1] : sin;

  generate
    if (SEG == 1) begin : g_one
      assign nxt = in_bit;
    end else begin : g_multi
      assign nxt = {seg[SEG-2:0], in_bit};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg  <= '0;
      sout <= 1'b0;
    end else if (load) begin
      seg <= din;
    end else if (shift) begin
      sout <= seg[SEG-1];
      seg  <= nxt;
    end
  end
endmodule

module scan_shifter #(
  parameter int WIDTH    = 192,
  parameter int CHANNELS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic                hold,
  input  logic [WIDTH-1:0]    data_in,
  input  logic [CHANNELS-1:0] shift_in,
  output logic [CHANNELS-1:0] shift_out,
  output logic                shift_valid,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    data_out
);
  localparam int SEG = WIDTH / CHANNELS;
  localparam int CW  = $clog2(SEG + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                         state;
  logic [CW-1:0]                  cnt;
  logic                           mode_q;
  logic                           load, shift;
  logic [CHANNELS-1:0][SEG-1:0]   segs;

  assign load     = (state == IDLE) && start;
  assign shift    = (state == SHIFT) && !hold;
  assign data_out = segs;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      scan_lane #(.SEG(SEG)) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .rot   (mode_q),
        .din   (data_in[c*SEG +: SEG]),
        .sin   (shift_in[c]),
        .seg   (segs[c]),
        .sout  (shift_out[c])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mode_q      <= 1'b0;
      shift_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          shift_valid <= 1'b0;
          done        <= 1'b0;
          if (start) begin
            cnt    <= '0;
            mode_q <= mode;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (hold) begin
            shift_valid <= 1'b0;
          end else begin
            shift_valid <= 1'b1;
            cnt         <= cnt + CW'(1);
            // Final bit leaves this edge; busy drops with done so a start can chain.
            if (cnt == CW'(SEG - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_shifter.sv
// Bench for scan_shifter: three configurations (8x1, 8x2, 192x1) checked every
// cycle against a bit-index model, plus hand-computed literal expectations.

module tb_scan_shifter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         st[3], md[3], hd[3];
  logic [191:0] din[3];
  logic [1:0]   sin[3];

  logic         so0, so2;
  logic [1:0]   so1;
  logic [7:0]   do0, do1;
  logic [191:0] do2;
  logic [2:0]   sv, bz, dn;

  logic [1:0]   so_a[3];
  logic [191:0] do_a[3];

  always_comb begin
    so_a[0] = {1'b0, so0};
    so_a[1] = so1;
    so_a[2] = {1'b0, so2};
    do_a[0] = {184'b0, do0};
    do_a[1] = {184'b0, do1};
    do_a[2] = do2;
  end

  int SEGS[3] = '{8, 4, 192};
  int CHS[3]  = '{1, 2, 1};
  int WID[3]  = '{8, 8, 192};

  scan_shifter #(.WIDTH(8), .CHANNELS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .mode(md[0]), .hold(hd[0]),
    .data_in(din[0][7:0]), .shift_in(sin[0][0]), .shift_out(so0),
    .shift_valid(sv[0]), .busy(bz[0]), .done(dn[0]), .data_out(do0));

  scan_shifter #(.WIDTH(8), .CHANNELS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .mode(md[1]), .hold(hd[1]),
    .data_in(din[1][7:0]), .shift_in(sin[1]), .shift_out(so1),
    .shift_valid(sv[1]), .busy(bz[1]), .done(dn[1]), .data_out(do1));

  scan_shifter #(.WIDTH(192), .CHANNELS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .mode(md[2]), .hold(hd[2]),
    .data_in(din[2]), .shift_in(sin[2][0]), .shift_out(so2),
    .shift_valid(sv[2]), .busy(bz[2]), .done(dn[2]), .data_out(do2));

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  function automatic logic [191:0] wmask(input int w);
    logic [191:0] one;
    one = 192'd1;
    return (w >= 192) ? '1 : ((one << w) - 192'd1);
  endfunction

  // Model: a sequence is "bit k of lane c = word[(c+1)*SEG-1-k]"; capture
  // places the k-th shift_in sample at segment bit SEG-1-k.
  logic         m_busy[3], m_done[3], m_val[3], m_mode[3];
  logic [1:0]   m_out[3];
  logic [191:0] m_word[3], m_res[3];
  int           m_k[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_val[i] <= 1'b0; m_mode[i] <= 1'b0;
        m_out[i]  <= '0;   m_word[i] <= '0;   m_res[i] <= '0;   m_k[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [191:0] r;
        logic [1:0]   o;
        logic         b, d, v;
        int           k;
        r = m_res[i]; o = m_out[i]; b = m_busy[i]; k = m_k[i]; d = 1'b0; v = 1'b0;
        if (!b) begin
          if (st[i]) begin
            b = 1'b1; k = 0;
            r = din[i] & wmask(WID[i]);
            m_word[i] <= din[i] & wmask(WID[i]);
            m_mode[i] <= md[i];
          end
        end else if (!hd[i]) begin
          for (int c = 0; c < CHS[i]; c++) begin
            o[c] = m_word[i][(c+1)*SEGS[i]-1-k];
            if (!m_mode[i]) r[c*SEGS[i]+SEGS[i]-1-k] = sin[i][c];
          end
          v = 1'b1;
          k++;
          if (k == SEGS[i]) begin b = 1'b0; d = 1'b1; end
        end
        m_res[i] <= r; m_out[i] <= o; m_busy[i] <= b; m_k[i] <= k;
        m_done[i] <= d; m_val[i] <= v;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy%0d", i),  {191'b0, bz[i]}, {191'b0, m_busy[i]});
        chk($sformatf("done%0d", i),  {191'b0, dn[i]}, {191'b0, m_done[i]});
        chk($sformatf("valid%0d", i), {191'b0, sv[i]}, {191'b0, m_val[i]});
        chk($sformatf("sout%0d", i),  {190'b0, so_a[i]}, {190'b0, m_out[i]});
        if (!m_busy[i]) chk($sformatf("dout%0d", i), do_a[i], m_res[i]);
      end
    end
  end

  // Runs one sequence on instance i starting at a negedge; returns at the
  // negedge where done is seen, so a following call chains back-to-back.
  task automatic run(input int i, input logic [191:0] d, input bit m,
                     input logic [1:0] si, input bit alt,
                     input int hold_at, input int hold_len, input int poke_at,
                     output logic [191:0] s_hi, output logic [191:0] s_lo,
                     output int cyc);
    int nsh;
    nsh = 0;
    din[i] = d & wmask(WID[i]); md[i] = m; sin[i] = si; st[i] = 1'b1;
    @(posedge clk); @(negedge clk);
    st[i] = 1'b0; md[i] = ~m;
    cyc = 0; s_hi = '0; s_lo = '0;
    while (cyc < 400) begin
      hd[i] = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      st[i] = (cyc == poke_at);
      if (cyc == poke_at) din[i] = ~din[i] & wmask(WID[i]);
      if (alt) sin[i] = (nsh % 2 == 0) ? 2'b11 : 2'b00;
      @(posedge clk); cyc++; @(negedge clk);
      if (sv[i]) begin
        nsh++;
        s_hi = {s_hi[190:0], so_a[i][CHS[i]-1]};
        s_lo = {s_lo[190:0], so_a[i][0]};
      end
      if (dn[i]) break;
    end
    st[i] = 1'b0; hd[i] = 1'b0;
    if (cyc >= 400) chk("timeout", 192'(cyc), 192'd0);
  endtask

  logic [191:0] hi, lo;
  int           c;

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; md[i] = 0; hd[i] = 0; din[i] = '0; sin[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("rst_busy", {189'b0, bz}, 192'd0);
    chk("rst_valid", {189'b0, sv}, 192'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // capture, 8x1
    run(0, 192'hA5, 1'b0, 2'b01, 1'b0, 1000, 0, 1000, hi, lo, c);
    chk("t1_stream", hi[7:0], 192'hA5);
    chk("t1_cyc", 192'(c), 192'd8);
    chk("t1_dout", {184'b0, do0}, 192'hFF);

    // rotate, 8x2
    run(1, 192'h3C, 1'b1, 2'b00, 1'b0, 1000, 0, 1000, hi, lo, c);
    chk("t2_lane1", hi[3:0], 192'b0011);
    chk("t2_lane0", lo[3:0], 192'b1100);
    chk("t2_cyc", 192'(c), 192'd4);
    chk("t2_dout", {184'b0, do1}, 192'h3C);

    // capture, 8x2, per-lane shift_in
    run(1, 192'h96, 1'b0, 2'b10, 1'b0, 1000, 0, 1000, hi, lo, c);
    chk("t2b_lane1", hi[3:0], 192'b1001);
    chk("t2b_lane0", lo[3:0], 192'b0110);
    chk("t2b_dout", {184'b0, do1}, 192'hF0);

    // three hold cycles mid-sequence
    run(0, 192'hA5, 1'b0, 2'b00, 1'b0, 3, 3, 1000, hi, lo, c);
    chk("t3_stream", hi[7:0], 192'hA5);
    chk("t3_cyc", 192'(c), 192'd11);
    chk("t3_dout", {184'b0, do0}, 192'h00);

    // start while busy ignored, start on done cycle chains
    run(0, 192'h5A, 1'b1, 2'b00, 1'b0, 1000, 0, 2, hi, lo, c);
    chk("t4a_stream", hi[7:0], 192'h5A);
    chk("t4a_cyc", 192'(c), 192'd8);
    run(0, 192'hC3, 1'b0, 2'b01, 1'b0, 1000, 0, 1000, hi, lo, c);
    chk("t4b_stream", hi[7:0], 192'hC3);
    chk("t4b_cyc", 192'(c), 192'd8);
    chk("t4b_dout", {184'b0, do0}, 192'hFF);

    // reset after three shifts
    din[0] = 192'hA5; md[0] = 1'b0; sin[0] = 2'b01; st[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    st[0] = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("t5_busy_pre", {191'b0, bz[0]}, 192'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sout", {191'b0, so0}, 192'd0);
    chk("t5_valid", {191'b0, sv[0]}, 192'd0);
    chk("t5_busy", {191'b0, bz[0]}, 192'd0);
    chk("t5_done", {191'b0, dn[0]}, 192'd0);
    chk("t5_dout", {184'b0, do0}, 192'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 192'h81, 1'b1, 2'b00, 1'b0, 1000, 0, 1000, hi, lo, c);
    chk("t5_cyc", 192'(c), 192'd8);
    chk("t5_dout2", {184'b0, do0}, 192'h81);

    // full width, alternating capture
    run(2, {6{32'hDEADBEEF}}, 1'b0, 2'b00, 1'b1, 1000, 0, 1000, hi, lo, c);
    chk("t6_stream", hi, {6{32'hDEADBEEF}});
    chk("t6_cyc", 192'(c), 192'd192);
    chk("t6_dout", do2, {96{2'b10}});

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scan_shifter.md
# scan_shifter

Parametrised multi-channel parallel-load / serial-shift scan register for the 3D self-test path. It loads a WIDTH-bit test word in one cycle and shifts it out MSB-first over CHANNELS parallel serial lanes. On the same cycles it captures returning serial data, or loops the word back on itself in rotate mode. A bit counter, busy/done handshake and hold stall replace the free-running enable-controlled shifting of the previous-generation single-lane register.

## Interface
- WIDTH, 192, total register width in bits; must be a multiple of CHANNELS.
- CHANNELS, 1, number of serial lanes; SEG = WIDTH/CHANNELS bits per lane.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request; accepted only when busy=0.
- mode  in  1  sampled with start: 0 = capture shift_in, 1 = rotate (lane MSB fed back to lane LSB).
- hold  in  1  stalls shifting for the cycle; ignored when idle.
- data_in  in  WIDTH  parallel word loaded on accepted start.
- shift_in  in  CHANNELS  serial capture bits; lane c enters at bit c*SEG.
- shift_out  out  CHANNELS  registered serial output; lane c = MSB of segment c, bit (c+1)*SEG-1.
- shift_valid  out  1  shift_out carries a new bit this cycle.
- busy  out  1  shift sequence in progress.
- done  out  1  one-cycle pulse: sequence complete, data_out valid.
- data_out  out  WIDTH  current register contents; meaningful when busy=0.

## Operation
- States: IDLE, SHIFT. Counter cnt, width $clog2(SEG+1), and latched mode bit mode_q.
- Reset: state=IDLE, register=0, cnt=0, mode_q=0, shift_out=0, shift_valid=0, busy=0, done=0.
- IDLE with start=1: register <= data_in, cnt <= 0, mode_q <= mode, state <= SHIFT, busy <= 1. With start=0, everything holds. shift_valid and done are cleared on every IDLE cycle.
- SHIFT with hold=0, per lane c:
  - shift_out[c] <= seg_c[SEG-1].
  - seg_c <= {seg_c[SEG-2:0], in_c}, where in_c = shift_in[c] if mode_q=0, else seg_c[SEG-1]. For SEG=1 the segment is replaced by in_c.
  - shift_valid <= 1, cnt <= cnt+1.
- SHIFT with hold=1: register, cnt and shift_out hold; shift_valid <= 0.
- Last shift (hold=0 and cnt=SEG-1): state <= IDLE, busy <= 0, done <= 1 for one cycle.
- start while busy=1: ignored and not queued. start in the cycle where done=1 is accepted, because busy is already 0, giving back-to-back sequences.
- mode and data_in are ignored except on an accepted start. mode changes during SHIFT have no effect.
- After a full sequence:
  - mode 0: segment c holds shift_in[c] samples, with the first sample at the MSB.
  - mode 1: the register equals the loaded data_in again.
- Reset asserted mid-sequence aborts immediately to the reset values. No done pulse is produced.

## Timing
- Start accepted at edge E0 (load). Shifts occur at edges E1..E(SEG+h), where h is the number of hold cycles.
- Bit k (k=0..SEG-1) of lane c is data_in[(c+1)*SEG-1-k]. It appears on shift_out one cycle after its shift edge, with shift_valid=1.
- done and the final shift_valid are high in the same cycle, SEG+h cycles after the start edge. busy is low in that cycle. data_out is valid from that cycle until the next accepted start.
- shift_in is sampled on the same edge that emits the corresponding shift_out bit.
- Total latency, start to done, is SEG cycles when h=0.

## Test plan
- WIDTH=8, CHANNELS=1, mode=0, data_in=8'hA5, shift_in=1, no hold → shift_out 1,0,1,0,0,1,0,1 with shift_valid on 8 consecutive cycles; done 8 cycles after start; data_out=8'hFF.
- WIDTH=8, CHANNELS=2, mode=1, data_in=8'h3C → lane1 emits 0,0,1,1; lane0 emits 1,1,0,0; done after 4 cycles; data_out=8'h3C.
- WIDTH=8, CHANNELS=1, hold=1 for 3 cycles mid-sequence → shift_valid=0 and shift_out/register frozen during hold; done at 11 cycles; bit order unchanged.
- start pulses during busy and on the done cycle → the mid-sequence start is ignored; the done-cycle start loads the new data_in with no idle gap.
- rst_n low after 3 shifts → all outputs 0 asynchronously, no done pulse; a new start after release runs a full sequence.
- WIDTH=192, CHANNELS=1, mode=0, shift_in = alternating 1,0,... → 192 shift_valid cycles, then data_out = {96{2'b10}}.
